// File: rtl/piso_word_reader.sv
`default_nettype none
// ============================================================================
// piso_word_reader: parallel-in, serial-out word streamer, valid/ready both sides
// Revision: 1.0
// ============================================================================
module piso_word_reader #(
  parameter int WIDTH     = 32,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             busy,
  output logic             done
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic             sout_valid_q;
  logic             sout_last_q;
  logic             done_q;
  logic [WIDTH-1:0] w_shifted;

  // Shift toward whichever end feeds sout, filling the vacated end with zero
  assign w_shifted = (LSB_FIRST != 0) ? {1'b0, shreg_q[WIDTH-1:1]}
                                      : {shreg_q[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      sout_valid_q <= 1'b0;
      sout_last_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            shreg_q      <= load_data;
            cnt_q        <= '0;
            sout_valid_q <= 1'b1;
            sout_last_q  <= 1'b0;
            state_q      <= SHIFT;
          end
        end
        SHIFT: begin
          if (sout_ready) begin
            shreg_q <= w_shifted;
            // The counter parks on the final index so it never wraps mid-word
            if (cnt_q == LAST_IDX) begin
              sout_valid_q <= 1'b0;
              sout_last_q  <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= DONE;
            end else begin
              cnt_q       <= cnt_q + ONE;
              sout_last_q <= ((cnt_q + ONE) == LAST_IDX);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign load_ready = (state_q == IDLE) && !clr;
  assign sout       = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[WIDTH-1];
  assign sout_valid = sout_valid_q;
  assign sout_last  = sout_last_q;
  assign busy       = sout_valid_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_word_reader.sv
`default_nettype none
// ============================================================================
// tb_piso_word_reader: checks MSB-first and LSB-first instances against a bit-order model
// Revision: 1.0
// ============================================================================
module tb_piso_word_reader;

  logic       clk;
  logic       clr;
  logic       load_valid;
  logic [7:0] load_data;
  logic       sout_ready;

  logic sout_m, sout_valid_m, sout_last_m, busy_m, done_m, load_ready_m;
  logic sout_l, sout_valid_l, sout_last_l, busy_l, done_l, load_ready_l;
  logic [5:0] obs_m, obs_l;

  int checks   = 0;
  int failures = 0;

  piso_word_reader #(.WIDTH(8), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .clr(clr), .load_valid(load_valid), .load_ready(load_ready_m),
    .load_data(load_data), .sout(sout_m), .sout_valid(sout_valid_m),
    .sout_ready(sout_ready), .sout_last(sout_last_m), .busy(busy_m), .done(done_m)
  );

  piso_word_reader #(.WIDTH(8), .LSB_FIRST(1)) dut_lsb (
    .clk(clk), .clr(clr), .load_valid(load_valid), .load_ready(load_ready_l),
    .load_data(load_data), .sout(sout_l), .sout_valid(sout_valid_l),
    .sout_ready(sout_ready), .sout_last(sout_last_l), .busy(busy_l), .done(done_l)
  );

  // Observed vector: {sout, sout_valid, sout_last, busy, done, load_ready}
  assign obs_m = {sout_m, sout_valid_m, sout_last_m, busy_m, done_m, load_ready_m};
  assign obs_l = {sout_l, sout_valid_l, sout_last_l, busy_l, done_l, load_ready_l};

  localparam logic [5:0] V_IDLE  = 6'b000001;
  localparam logic [5:0] V_RESET = 6'b000000;
  localparam logic [5:0] V_DONE  = 6'b000010;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // Streams one word; bit k of the stream is w[7-k] MSB-first and w[k] LSB-first.
  task automatic stream_word(input logic [7:0] w, input int stall_pct, input int stall_at,
                             input int stall_len, input bit busy_load, output int beat_cycles);
    int idx, cyc, stalled;
    bit rdy;
    logic [5:0] exp_m, exp_l;
    idx = 0; cyc = 0; stalled = 0;
    load_valid = 1'b1; load_data = w; sout_ready = 1'($urandom);
    @(negedge clk);
    checks += 2;
    if (obs_m !== V_IDLE) begin failures++; $display("FAIL pre_load_msb obs=%b exp=%b", obs_m, V_IDLE); end
    if (obs_l !== V_IDLE) begin failures++; $display("FAIL pre_load_lsb obs=%b exp=%b", obs_l, V_IDLE); end
    @(posedge clk); #1;
    load_valid = busy_load;
    load_data  = busy_load ? 8'hFF : 8'($urandom);
    while (idx < 8 && cyc < 200) begin
      if (idx == stall_at && stalled < stall_len) begin
        rdy = 1'b0; stalled++;
      end else begin
        rdy = ($urandom_range(99) >= stall_pct);
      end
      sout_ready = rdy;
      @(negedge clk);
      exp_m = {w[7-idx], 1'b1, (idx == 7), 1'b1, 1'b0, 1'b0};
      exp_l = {w[idx],   1'b1, (idx == 7), 1'b1, 1'b0, 1'b0};
      checks += 2;
      if (obs_m !== exp_m) begin failures++; $display("FAIL beat_msb w=%h idx=%0d obs=%b exp=%b", w, idx, obs_m, exp_m); end
      if (obs_l !== exp_l) begin failures++; $display("FAIL beat_lsb w=%h idx=%0d obs=%b exp=%b", w, idx, obs_l, exp_l); end
      @(posedge clk); #1;
      if (rdy) idx++;
      cyc++;
    end
    checks++;
    if (idx != 8) begin failures++; $display("FAIL stream_timeout w=%h beats=%0d exp=8", w, idx); end
    beat_cycles = cyc;
    sout_ready = 1'($urandom);
    @(negedge clk);
    checks += 2;
    if (obs_m !== V_DONE) begin failures++; $display("FAIL done_msb w=%h obs=%b exp=%b", w, obs_m, V_DONE); end
    if (obs_l !== V_DONE) begin failures++; $display("FAIL done_lsb w=%h obs=%b exp=%b", w, obs_l, V_DONE); end
    @(posedge clk); #1;
    @(negedge clk);
    checks += 2;
    if (obs_m !== V_IDLE) begin failures++; $display("FAIL post_idle_msb w=%h obs=%b exp=%b", w, obs_m, V_IDLE); end
    if (obs_l !== V_IDLE) begin failures++; $display("FAIL post_idle_lsb w=%h obs=%b exp=%b", w, obs_l, V_IDLE); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; load_valid = 1'b1; load_data = 8'($urandom); sout_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 2;
    if (obs_m !== V_RESET) begin failures++; $display("FAIL reset_held_msb obs=%b exp=%b", obs_m, V_RESET); end
    if (obs_l !== V_RESET) begin failures++; $display("FAIL reset_held_lsb obs=%b exp=%b", obs_l, V_RESET); end
    @(posedge clk); #1;
    clr = 1'b0; load_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (obs_m !== V_IDLE) begin failures++; $display("FAIL reset_release_msb obs=%b exp=%b", obs_m, V_IDLE); end
    if (obs_l !== V_IDLE) begin failures++; $display("FAIL reset_release_lsb obs=%b exp=%b", obs_l, V_IDLE); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int cyc;
    stream_word(8'hA5, 0, -1, 0, 1'b0, cyc);
    checks++;
    if (cyc != 8) begin failures++; $display("FAIL basic_latency cycles=%0d exp=8", cyc); end
    stream_word(8'h3C, 0, -1, 0, 1'b0, cyc);
    checks++;
    if (cyc != 8) begin failures++; $display("FAIL lsb_latency cycles=%0d exp=8", cyc); end
  endtask

  task automatic test_backpressure();
    int cyc;
    stream_word(8'hF0, 0, 2, 3, 1'b0, cyc);
    checks++;
    if (cyc != 11) begin failures++; $display("FAIL backpressure_cycles cycles=%0d exp=11", cyc); end
  endtask

  task automatic test_load_while_busy();
    int cyc;
    logic [5:0] exp_v;
    stream_word(8'h81, 0, -1, 0, 1'b1, cyc);
    load_valid = 1'b0; load_data = 8'h00; sout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_v = {1'b1, 1'b1, (i == 7), 1'b1, 1'b0, 1'b0};
      checks += 2;
      if (obs_m !== exp_v) begin failures++; $display("FAIL queued_ff_msb idx=%0d obs=%b exp=%b", i, obs_m, exp_v); end
      if (obs_l !== exp_v) begin failures++; $display("FAIL queued_ff_lsb idx=%0d obs=%b exp=%b", i, obs_l, exp_v); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (obs_m !== V_DONE) begin failures++; $display("FAIL queued_ff_done obs=%b exp=%b", obs_m, V_DONE); end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_word();
    int cyc;
    logic [7:0] w;
    logic [5:0] exp_m, exp_l;
    w = 8'hA5;
    load_valid = 1'b1; load_data = w; sout_ready = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_m = {w[7-i], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs_m !== exp_m) begin failures++; $display("FAIL midword_beat idx=%0d obs=%b exp=%b", i, obs_m, exp_m); end
      @(posedge clk); #1;
    end
    clr = 1'b1;
    @(negedge clk);
    exp_m = {w[3], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_l = {w[4], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    checks += 2;
    if (obs_m !== exp_m) begin failures++; $display("FAIL clr_high_msb obs=%b exp=%b", obs_m, exp_m); end
    if (obs_l !== exp_l) begin failures++; $display("FAIL clr_high_lsb obs=%b exp=%b", obs_l, exp_l); end
    @(posedge clk); #1;
    clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks += 2;
      if (obs_m !== V_IDLE) begin failures++; $display("FAIL after_clr_msb cyc=%0d obs=%b exp=%b", i, obs_m, V_IDLE); end
      if (obs_l !== V_IDLE) begin failures++; $display("FAIL after_clr_lsb cyc=%0d obs=%b exp=%b", i, obs_l, V_IDLE); end
      @(posedge clk); #1;
    end
    stream_word(8'h01, 0, -1, 0, 1'b0, cyc);
  endtask

  task automatic test_simultaneous();
    clr = 1'b1; load_valid = 1'b1; load_data = 8'h5A; sout_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (load_ready_m !== 1'b0) begin failures++; $display("FAIL clr_load_ready obs=%b exp=0", load_ready_m); end
    @(posedge clk); #1;
    clr = 1'b0; load_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (obs_m !== V_IDLE) begin failures++; $display("FAIL clr_vs_load_msb obs=%b exp=%b", obs_m, V_IDLE); end
    if (obs_l !== V_IDLE) begin failures++; $display("FAIL clr_vs_load_lsb obs=%b exp=%b", obs_l, V_IDLE); end
    @(posedge clk); #1;
    load_valid = 1'b1; load_data = 8'hC3;
    @(posedge clk); #1;
    load_valid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++;
    if (sout_last_m !== 1'b1) begin failures++; $display("FAIL final_beat_last obs=%b exp=1", sout_last_m); end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks += 2;
      if (obs_m !== V_IDLE) begin failures++; $display("FAIL clr_vs_final_msb cyc=%0d obs=%b exp=%b", i, obs_m, V_IDLE); end
      if (obs_l !== V_IDLE) begin failures++; $display("FAIL clr_vs_final_lsb cyc=%0d obs=%b exp=%b", i, obs_l, V_IDLE); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    int cyc;
    for (int n = 0; n < 12; n++) begin
      stream_word(8'($urandom), 40, -1, 0, 1'b0, cyc);
      repeat ($urandom_range(2)) begin
        sout_ready = 1'($urandom);
        @(negedge clk);
        checks++;
        if (obs_m !== V_IDLE) begin failures++; $display("FAIL random_gap obs=%b exp=%b", obs_m, V_IDLE); end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    clr = 1'b1; load_valid = 1'b0; load_data = 8'h00; sout_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_load_while_busy();
    test_reset_mid_word();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso_word_reader.md
Name: piso_word_reader

Overview:
- Parallel-in, serial-out reader for word-wide register contents. It accepts a WIDTH-bit word over a valid/ready load handshake.
- It streams the word out one bit per accepted beat over a valid/ready serial handshake.
- It sits on the read side of the processor's register/MMIO storage and feeds serial peripherals and debug taps.
- All state is rising-edge clocked on clk, with synchronous clear.

Parameters:
- WIDTH, 32, word width in bits; legal range 2..64.
- LSB_FIRST, 0, 0 = MSB shifted out first; 1 = LSB shifted out first.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  synchronous, active-high reset.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  word to serialize.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout holds a valid bit.
- sout_ready  input  1  consumer accepts sout this cycle.
- sout_last  output  1  current bit is the final bit of the word.
- busy  output  1  a word is loaded and not yet fully emitted.
- done  output  1  one-cycle pulse after the final bit is accepted.

Behaviour:
- Interface: one clock, clk. Reset is clr: synchronous and active-high, sampled only on the rising edge of clk.
- Reset: clr high at a rising edge forces state IDLE, shift register 0, bit counter 0.
  - Reset values: load_ready=1 (after the reset edge, while clr is low), sout=0, sout_valid=0, sout_last=0, busy=0, done=0.
  - While clr is high, load_ready=0 combinationally and no load is accepted.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load_ready=1, sout_valid=0, busy=0.
  - A load is accepted when load_valid & load_ready at an edge: capture load_data, counter <= 0, go to SHIFT.
- SHIFT:
  - sout_valid=1, busy=1, load_ready=0.
  - sout = shreg[WIDTH-1] when LSB_FIRST=0; sout = shreg[0] when LSB_FIRST=1.
  - The first bit appears the cycle after the load edge (load-to-first-bit latency 1).
- Beat accepted (sout_valid & sout_ready at an edge):
  - Shift register shifts toward the output end, filling with 0.
  - Counter increments.
- Stall (sout_ready=0): sout, sout_valid, sout_last and the counter hold exactly. There is no timeout.
- sout_last = 1 in SHIFT when counter == WIDTH-1.
- When the last beat is accepted: go to DONE.
- DONE (exactly one cycle):
  - done=1, busy=0, sout_valid=0, load_ready=0.
  - Next state: IDLE.
  - Minimum word-to-word period is WIDTH+2 cycles with sout_ready held high.
- Counter width is clog2(WIDTH) bits. It never wraps mid-word and resets to 0 on each load.
- load_valid in SHIFT/DONE is ignored; load_data is not captured.
  - The producer must hold the word until load_ready.
- clr mid-SHIFT: the partial word is discarded and no done pulse is generated.
  - The next cycle is IDLE with reset values.
- clr on the same edge as a load handshake or a final beat: clr wins; no capture, no done.
- sout_ready while sout_valid=0 has no effect.

Test Plan:
- Basic MSB-first, WIDTH=8, LSB_FIRST=0: reset, load 0xA5 with sout_ready=1.
  - Cycles 1..8: sout = 1,0,1,0,0,1,0,1, sout_valid=1.
  - sout_last=1 only in cycle 8; done=1 in cycle 9; load_ready=1 in cycle 10.
- LSB-first, WIDTH=8, LSB_FIRST=1: load 0x3C -> sout = 0,0,1,1,1,1,0,0, then done pulse.
- Backpressure: load 0xF0 and drop sout_ready for 3 cycles after bit 2.
  - sout and counter hold through the stall.
  - Output sequence is still 1,1,1,1,0,0,0,0; done is delayed 3 cycles.
- Load while busy: assert load_valid with 0xFF during SHIFT of 0x81.
  - load_ready=0 and output remains 1,0,0,0,0,0,0,1.
  - 0xFF is accepted only in the next IDLE.
- Reset mid-word: assert clr after bit 4 of 0xA5.
  - Next cycle: sout_valid=0, busy=0, load_ready=1; no done pulse.
  - A new load of 0x01 then emits 0,0,0,0,0,0,0,1.
- Simultaneous events: clr high on the same edge as a load_valid handshake -> no capture, state IDLE. Separately, clr on the final-beat edge -> done stays 0.
